// File: rtl/alu_bist_if.sv
// ALU opcode package and the ALU connection interface.
//
// alu_pkg::aluop_t : ALU opcodes in declaration order. The BIST engine steps
//                    through them in exactly this order.
// alu_if           : bundle between an initiator and the ALU.
//   modport tb  : drives aluop, a, b; receives out, negative, overflow, zero
//   modport alu : the reverse view, for the ALU itself
package alu_pkg;
    typedef enum logic [3:0] {
        ALU_SLL,
        ALU_SRL,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLTU
    } aluop_t;
endpackage

interface alu_if;
    import alu_pkg::*;

    aluop_t      aluop;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] out;
    logic        negative;
    logic        overflow;
    logic        zero;

    modport tb  (output aluop, a, b, input out, negative, overflow, zero);
    modport alu (input aluop, a, b, output out, negative, overflow, zero);
endinterface

// File: rtl/alu_bist.sv
// Built-in self-test engine for the ALU.
//
// Drives pseudo-random operands from two Galois LFSRs and a cycling opcode
// into the ALU, and folds every result plus its flags into a 32-bit MISR.
//
// Ports:
//   CLK        in   single clock, rising edge
//   nRST       in   asynchronous active-low reset
//   start      in   request a run; honoured in IDLE or DONE
//   abort      in   cancel the run; honoured in RUN, beats start
//   npatterns  in   16-bit vector count, latched on an accepted start
//   busy       out  high exactly while in RUN
//   done       out  high while in DONE
//   signature  out  current MISR value
//   fsm_state  out  raw FSM state (IDLE=0, RUN=1, DONE=2) for observation
//   aluif      tb   ALU connection: drives aluop/a/b, samples out and flags
//
// Handshake: start and abort are single-cycle level requests sampled on the
// rising edge; there is no ready signal, a request that arrives in a state
// that does not sample it is simply dropped.
module alu_bist
    import alu_pkg::*;
#(
    parameter logic [31:0] SEED_A    = 32'hACE1_2468,
    parameter logic [31:0] SEED_B    = 32'h1357_9BDF,
    parameter logic [31:0] MISR_INIT = 32'hFFFF_FFFF
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] npatterns,
    output logic        busy,
    output logic        done,
    output logic [31:0] signature,
    output logic [1:0]  fsm_state,
    alu_if.tb           aluif
);

    // Feedback taps of x^32+x^22+x^2+x+1, shared by the LFSRs and the MISR.
    localparam logic [31:0] POLY = 32'h0040_0007;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] a_q;
    logic [31:0] b_q;
    aluop_t      op_q;
    logic [31:0] misr;
    logic [15:0] cnt;
    logic [15:0] n_q;
    logic        last_vec;
    logic [31:0] misr_next;

    function automatic logic [31:0] lfsr_step(input logic [31:0] r);
        return {r[30:0], 1'b0} ^ (r[31] ? POLY : 32'h0);
    endfunction

    function automatic aluop_t op_step(input aluop_t op);
        if (op == ALU_SLTU) begin
            return ALU_SLL;
        end
        return aluop_t'(op + 4'd1);
    endfunction

    // n_q is never zero while in RUN, so N-1 does not wrap here.
    assign last_vec = (cnt == (n_q - 16'd1));

    assign misr_next = {misr[30:0], 1'b0} ^ (misr[31] ? POLY : 32'h0)
                     ^ aluif.out
                     ^ {29'b0, aluif.negative, aluif.overflow, aluif.zero};

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = (npatterns == 16'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (last_vec) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: vector generators, counters and signature.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            a_q  <= 32'h0;
            b_q  <= 32'h0;
            op_q <= ALU_SLL;
            misr <= MISR_INIT;
            cnt  <= 16'd0;
            n_q  <= 16'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_q  <= SEED_A;
                        b_q  <= SEED_B;
                        op_q <= ALU_SLL;
                        misr <= MISR_INIT;
                        cnt  <= 16'd0;
                        n_q  <= npatterns;
                    end
                end
                RUN: begin
                    if (abort) begin
                        // Abort discards the vector on the bus: the signature
                        // keeps only the vectors already absorbed.
                        a_q  <= 32'h0;
                        b_q  <= 32'h0;
                        op_q <= ALU_SLL;
                    end else begin
                        misr <= misr_next;
                        if (last_vec) begin
                            a_q  <= 32'h0;
                            b_q  <= 32'h0;
                            op_q <= ALU_SLL;
                        end else begin
                            cnt  <= cnt + 16'd1;
                            a_q  <= lfsr_step(a_q);
                            b_q  <= lfsr_step(b_q);
                            op_q <= op_step(op_q);
                        end
                    end
                end
                default: begin
                    a_q  <= 32'h0;
                    b_q  <= 32'h0;
                    op_q <= ALU_SLL;
                end
            endcase
        end
    end

    assign aluif.a     = a_q;
    assign aluif.b     = b_q;
    assign aluif.aluop = op_q;

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign signature = misr;
    assign fsm_state = state;

endmodule

// File: tb/tb_alu_bist.sv
module tb_alu_bist;
    import alu_pkg::*;

    localparam logic [31:0] SEED_A    = 32'hACE1_2468;
    localparam logic [31:0] SEED_B    = 32'h1357_9BDF;
    localparam logic [31:0] MISR_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] POLY      = 32'h0040_0007;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] npatterns = 16'd0;
    logic        busy;
    logic        done;
    logic [31:0] signature;
    logic [1:0]  fsm_state;
    logic        fault_add = 1'b0;

    always #5 clk = ~clk;

    alu_if bus ();

    alu_bist dut (
        .CLK       (clk),
        .nRST      (n_rst),
        .start     (start),
        .abort     (abort),
        .npatterns (npatterns),
        .busy      (busy),
        .done      (done),
        .signature (signature),
        .fsm_state (fsm_state),
        .aluif     (bus)
    );

    // ---------------- reference ALU and model ----------------
    aluop_t op_seq [10] = '{ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
                            ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU};

    // Returns {out, negative, overflow, zero}.
    function automatic logic [34:0] alu_ref(input aluop_t op, input logic [31:0] a,
                                            input logic [31:0] b, input bit fault);
        logic [31:0] r;
        logic        v;
        r = 32'h0;
        v = 1'b0;
        case (op)
            ALU_SLL:  r = a << b[4:0];
            ALU_SRL:  r = a >> b[4:0];
            ALU_ADD: begin
                r = a + b;
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            ALU_SUB: begin
                r = a - b;
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_NOR:  r = ~(a | b);
            ALU_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            default:  r = 32'h0;
        endcase
        if (fault && op == ALU_ADD) r[0] = 1'b0;
        return {r, r[31], v, (r == 32'h0)};
    endfunction

    assign {bus.out, bus.negative, bus.overflow, bus.zero} =
        alu_ref(bus.aluop, bus.a, bus.b, fault_add);

    function automatic logic [31:0] lfsr(input logic [31:0] r);
        return (r << 1) ^ (r[31] ? POLY : 32'h0);
    endfunction

    function automatic logic [31:0] vec_a(input int i);
        logic [31:0] r = SEED_A;
        for (int k = 0; k < i; k++) r = lfsr(r);
        return r;
    endfunction

    function automatic logic [31:0] vec_b(input int i);
        logic [31:0] r = SEED_B;
        for (int k = 0; k < i; k++) r = lfsr(r);
        return r;
    endfunction

    // Signature after the first `absorbed` vectors have been compressed.
    function automatic logic [31:0] model_sig(input int absorbed, input bit fault);
        logic [31:0] m = MISR_INIT;
        logic [31:0] a = SEED_A;
        logic [31:0] b = SEED_B;
        logic [34:0] res;
        for (int i = 0; i < absorbed; i++) begin
            res = alu_ref(op_seq[i % 10], a, b, fault);
            m = (m << 1) ^ (m[31] ? POLY : 32'h0) ^ res[34:3] ^ {29'b0, res[2:0]};
            a = lfsr(a);
            b = lfsr(b);
        end
        return m;
    endfunction

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int n);
        start     = 1'b1;
        npatterns = 16'(n);
        tick();
        start     = 1'b0;
    endtask

    // Runs the remaining vectors of an accepted start (now in cycle t+0) to
    // completion, checking each vector when asked, then checks done/signature.
    task automatic finish_run(input int n, input bit chk_vec, input bit fault, input string tag);
        for (int i = 0; i < n; i++) begin
            if (chk_vec) begin
                check({tag, "_a"}, bus.a, vec_a(i));
                check({tag, "_b"}, bus.b, vec_b(i));
                check({tag, "_op"}, 32'(bus.aluop), 32'(op_seq[i % 10]));
            end
            if (i == 0)     check({tag, "_busy_first"}, 32'(busy), 32'd1);
            if (i == n - 1) check({tag, "_done_early"}, 32'(done), 32'd0);
            tick();
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_sig"}, signature, model_sig(n, fault));
        check({tag, "_idle_a"}, bus.a, 32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int k;
        logic [31:0] sig1;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sig", signature, MISR_INIT);
        n_rst = 1'b1;
        tick();

        // N=3 directed run
        start_run(3);
        check("n3_a0", bus.a, 32'hACE1_2468);
        check("n3_b0", bus.b, 32'h1357_9BDF);
        check("n3_op0", 32'(bus.aluop), 32'(ALU_SLL));
        tick();
        check("n3_a1", bus.a, 32'h5982_48D7);
        check("n3_b1", bus.b, 32'h26AF_37BE);
        check("n3_op1", 32'(bus.aluop), 32'(ALU_SRL));
        tick();
        check("n3_busy2", 32'(busy), 32'd1);
        check("n3_done2", 32'(done), 32'd0);
        tick();
        check("n3_done", 32'(done), 32'd1);
        check("n3_sig", signature, model_sig(3, 1'b0));
        tick();
        check("n3_hold", signature, model_sig(3, 1'b0));

        // N=0 from DONE
        start_run(0);
        check("n0_done", 32'(done), 32'd1);
        check("n0_busy", 32'(busy), 32'd0);
        check("n0_sig", signature, MISR_INIT);
        tick();

        // N=12: opcode wrap on vectors 10 and 11
        start_run(12);
        finish_run(12, 1'b1, 1'b0, "n12");

        // Mid-run asynchronous reset
        start_run(50);
        repeat (10) tick();
        n_rst = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_sig", signature, MISR_INIT);
        check("arst_a", bus.a, 32'h0);
        check("arst_b", bus.b, 32'h0);
        check("arst_op", 32'(bus.aluop), 32'(ALU_SLL));
        #2;
        n_rst = 1'b1;
        tick();

        // Abort at cnt=5 of N=20, start ignored alongside it
        start_run(20);
        repeat (5) tick();
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("abort_state", 32'(fsm_state), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sig", signature, model_sig(5, 1'b0));
        check("abort_a", bus.a, 32'h0);
        tick();
        check("abort_hold", signature, model_sig(5, 1'b0));
        start_run(20);
        finish_run(20, 1'b0, 1'b0, "post_abort");

        // start during RUN ignored
        start_run(6);
        tick();
        start = 1'b1;
        npatterns = 16'd40;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("run_start_ign_done", 32'(done), 32'd0);
        tick();
        check("run_start_ign_done2", 32'(done), 32'd1);
        check("run_start_ign_sig", signature, model_sig(6, 1'b0));

        // Randomized full runs and aborts
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 40);
            start_run(n);
            finish_run(n, 1'b1, 1'b0, "rand_run");
        end
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(8, 30);
            k = $urandom_range(1, n - 1);
            start_run(n);
            repeat (k) tick();
            abort = 1'b1;
            tick();
            abort = 1'b0;
            check("rand_abort_busy", 32'(busy), 32'd0);
            check("rand_abort_sig", signature, model_sig(k, 1'b0));
            tick();
        end

        // Faulty ALU: stuck-at-0 bit 0 on ADD
        fault_add = 1'b1;
        start_run(100);
        finish_run(100, 1'b0, 1'b1, "fault");
        total++;
        assert (signature !== model_sig(100, 1'b0)) else begin
            bad++;
            $error("FAIL fault_vs_golden: observed=%h expected!=%h", signature, model_sig(100, 1'b0));
        end
        fault_add = 1'b0;
        tick();

        // Two clean back-to-back runs, restart from DONE
        start_run(100);
        finish_run(100, 1'b0, 1'b0, "golden1");
        sig1 = signature;
        start_run(100);
        check("restart_done_drop", 32'(done), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        finish_run(100, 1'b0, 1'b0, "golden2");
        check("back_to_back", signature, sig1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
